apb_fsm_controller: RTL and testbench

- Downstream stage of the AHB slave interface in the AHB-to-APB bridge.
- Consumes the slave interface's pipelined address, data and control (valid, Haddr/Haddr1/Haddr2, Hwdata/Hwdata1, Hwrite/Hwritereg).
- Sequences APB SETUP/ENABLE phases on the Pselx/Penable bus and drives Hreadyout back to the AHB master.
- Supports single and back-to-back pipelined transfers.

---
 rtl/apb_fsm_controller.sv | 85 ++++++++
 tb/tb_apb_fsm_controller.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/apb_fsm_controller.sv
// apb_fsm_controller: sequences APB SETUP/ENABLE phases from the pipelined AHB slave interface
module apb_fsm_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    output logic [2:0]        Pselx,
    output logic              Penable,
    output logic              Pwrite,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata,
    output logic              Hreadyout
);
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_WWAIT    = 3'd1;
    localparam logic [2:0] ST_READ     = 3'd2;
    localparam logic [2:0] ST_WRITE    = 3'd3;
    localparam logic [2:0] ST_WRITEP   = 3'd4;
    localparam logic [2:0] ST_RENABLE  = 3'd5;
    localparam logic [2:0] ST_WENABLE  = 3'd6;
    localparam logic [2:0] ST_WENABLEP = 3'd7;
    logic [2:0]        state, nxt, sel;
    logic              ld_rd, ld_wr, src2, en;
    logic [ADDR_W-1:0] addr_ld;
    always_comb begin
        nxt = ST_IDLE;
        case (state)
            ST_IDLE:     nxt = !valid ? ST_IDLE : Hwrite ? ST_WWAIT : ST_READ;
            ST_WWAIT:    nxt = valid ? ST_WRITEP : ST_WRITE;
            ST_READ:     nxt = ST_RENABLE;
            ST_WRITE:    nxt = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP:   nxt = ST_WENABLEP;
            ST_RENABLE,
            ST_WENABLE:  nxt = !valid ? ST_IDLE : Hwrite ? ST_WWAIT : ST_READ;
            ST_WENABLEP: nxt = !Hwritereg ? ST_READ : valid ? ST_WRITEP : ST_WRITE;
            default:     nxt = ST_IDLE;
        endcase
    end
    assign ld_rd   = nxt == ST_READ;
    assign ld_wr   = nxt == ST_WRITE || nxt == ST_WRITEP;
    assign src2    = state == ST_WENABLEP;
    assign en      = nxt == ST_RENABLE || nxt == ST_WENABLE || nxt == ST_WENABLEP;
    assign addr_ld = ld_rd ? Haddr : src2 ? Haddr2 : Haddr1;
    assign sel     = addr_ld[27:26] == 2'b00 ? 3'b001 :
                     addr_ld[27:26] == 2'b01 ? 3'b010 :
                     addr_ld[27:26] == 2'b10 ? 3'b100 : 3'b000;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= '0;
            Pwdata    <= '0;
            Hreadyout <= 1'b1;
        end else begin
            state <= nxt;
            if (ld_rd || ld_wr) begin
                Paddr     <= addr_ld;
                Pselx     <= sel;
                Pwrite    <= ld_wr;
                Penable   <= 1'b0;
                Hreadyout <= 1'b0;
                if (ld_wr)
                    Pwdata <= src2 ? Hwdata1 : Hwdata;
            end else if (en) begin
                Penable   <= 1'b1;
                Hreadyout <= 1'b1;
            end else begin
                Pselx     <= '0;
                Penable   <= 1'b0;
                Hreadyout <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_apb_fsm_controller.sv
// tb_apb_fsm_controller: directed vectors for the APB FSM controller
module tb_apb_fsm_controller;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        valid = 1'b0;
    logic        Hwrite = 1'b0;
    logic        Hwritereg = 1'b0;
    logic [31:0] Haddr = '0;
    logic [31:0] Haddr1 = '0;
    logic [31:0] Haddr2 = '0;
    logic [31:0] Hwdata = '0;
    logic [31:0] Hwdata1 = '0;
    logic [2:0]  Pselx;
    logic        Penable, Pwrite, Hreadyout;
    logic [31:0] Paddr, Pwdata;
    logic        pen_prev = 1'b0;
    int          vectors = 0;
    int          miscompares = 0;
    apb_fsm_controller #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .valid(valid), .Hwrite(Hwrite), .Hwritereg(Hwritereg),
        .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata(Hwdata), .Hwdata1(Hwdata1),
        .Pselx(Pselx), .Penable(Penable), .Pwrite(Pwrite), .Paddr(Paddr), .Pwdata(Pwdata),
        .Hreadyout(Hreadyout)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        Haddr1    <= Haddr;
        Haddr2    <= Haddr1;
        Hwritereg <= Hwrite;
        Hwdata1   <= Hwdata;
    end
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
        check("penable_pair", 64'(pen_prev & Penable), 64'd0);
        pen_prev = Penable;
    endtask
    task automatic idle_chk(input string tag);
        check({tag, "_psel"}, 64'(Pselx), 64'd0);
        check({tag, "_pen"}, 64'(Penable), 64'd0);
        check({tag, "_hready"}, 64'(Hreadyout), 64'd1);
    endtask
    task automatic setup_chk(input string tag, input logic [31:0] a, input logic w, input logic [2:0] s);
        check({tag, "_paddr"}, 64'(Paddr), 64'(a));
        check({tag, "_pwrite"}, 64'(Pwrite), 64'(w));
        check({tag, "_psel"}, 64'(Pselx), 64'(s));
        check({tag, "_pen"}, 64'(Penable), 64'd0);
        check({tag, "_hready"}, 64'(Hreadyout), 64'd0);
    endtask
    task automatic enable_chk(input string tag, input logic [31:0] a, input logic [2:0] s);
        check({tag, "_paddr"}, 64'(Paddr), 64'(a));
        check({tag, "_psel"}, 64'(Pselx), 64'(s));
        check({tag, "_pen"}, 64'(Penable), 64'd1);
        check({tag, "_hready"}, 64'(Hreadyout), 64'd1);
    endtask
    initial begin
        tick();
        idle_chk("rst");
        check("rst_paddr", 64'(Paddr), 64'd0);
        check("rst_pwdata", 64'(Pwdata), 64'd0);
        check("rst_pwrite", 64'(Pwrite), 64'd0);
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            idle_chk("idle");
        end
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8000_0010;
        tick();
        valid = 1'b0;
        setup_chk("rd", 32'h8000_0010, 1'b0, 3'b001);
        tick();
        enable_chk("rd_en", 32'h8000_0010, 3'b001);
        tick();
        idle_chk("rd_done");
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0020;
        tick();
        valid = 1'b0; Hwdata = 32'hDEAD_BEEF;
        idle_chk("wr_wait");
        tick();
        setup_chk("wr", 32'h8400_0020, 1'b1, 3'b010);
        check("wr_pwdata", 64'(Pwdata), 64'hDEAD_BEEF);
        tick();
        enable_chk("wr_en", 32'h8400_0020, 3'b010);
        check("wr_en_pwdata", 64'(Pwdata), 64'hDEAD_BEEF);
        tick();
        idle_chk("wr_done");
        check("wr_done_paddr", 64'(Paddr), 64'h8400_0020);
        check("wr_done_pwrite", 64'(Pwrite), 64'd1);
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8800_0000;
        tick();
        idle_chk("b2b_wait");
        Haddr = 32'h8800_0004; Hwdata = 32'h1111_1111;
        tick();
        setup_chk("b2b0", 32'h8800_0000, 1'b1, 3'b100);
        check("b2b0_pwdata", 64'(Pwdata), 64'h1111_1111);
        valid = 1'b0; Hwdata = 32'h2222_2222;
        tick();
        enable_chk("b2b0_en", 32'h8800_0000, 3'b100);
        tick();
        setup_chk("b2b1", 32'h8800_0004, 1'b1, 3'b100);
        check("b2b1_pwdata", 64'(Pwdata), 64'h2222_2222);
        tick();
        enable_chk("b2b1_en", 32'h8800_0004, 3'b100);
        check("b2b1_en_pwdata", 64'(Pwdata), 64'h2222_2222);
        tick();
        idle_chk("b2b_done");
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8000_0000;
        tick();
        Hwrite = 1'b0; Haddr = 32'h8000_0008; Hwdata = 32'hCAFE_F00D;
        tick();
        setup_chk("wr_rd_w", 32'h8000_0000, 1'b1, 3'b001);
        check("wr_rd_pwdata", 64'(Pwdata), 64'hCAFE_F00D);
        valid = 1'b0;
        tick();
        enable_chk("wr_rd_wen", 32'h8000_0000, 3'b001);
        tick();
        setup_chk("wr_rd_r", 32'h8000_0008, 1'b0, 3'b001);
        tick();
        enable_chk("wr_rd_ren", 32'h8000_0008, 3'b001);
        tick();
        idle_chk("wr_rd_done");
        valid = 1'b1; Hwrite = 1'b1; Haddr = 32'h8400_0040;
        tick();
        valid = 1'b0; Hwdata = 32'h1234_5678;
        tick();
        setup_chk("ar_wr", 32'h8400_0040, 1'b1, 3'b010);
        tick();
        enable_chk("ar_wen", 32'h8400_0040, 3'b010);
        #3 rst = 1'b0;
        #1;
        idle_chk("async");
        check("async_paddr", 64'(Paddr), 64'd0);
        check("async_pwdata", 64'(Pwdata), 64'd0);
        check("async_pwrite", 64'(Pwrite), 64'd0);
        pen_prev = 1'b0;
        #2 rst = 1'b1;
        tick();
        idle_chk("post_rst");
        valid = 1'b1; Hwrite = 1'b0; Haddr = 32'h8800_0030;
        tick();
        valid = 1'b0;
        setup_chk("post_rd", 32'h8800_0030, 1'b0, 3'b100);
        tick();
        enable_chk("post_rd_en", 32'h8800_0030, 3'b100);
        tick();
        idle_chk("post_rd_done");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
